// File: rtl/rrf_free_list_if.sv
// Commit, allocation and RRF-query bus between the ROB/rename side and the
// retirement register file / physical-register free list.
interface rrf_free_list_if #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32
);
  localparam int unsigned PD_W    = $clog2(NUM_PHYS);
  localparam int unsigned RD_W    = $clog2(NUM_ARCH);
  localparam int unsigned OCC_W   = $clog2(NUM_PHYS - NUM_ARCH) + 1;
  localparam int unsigned COUNT_W = 64;

  logic               commit_valid;
  logic [PD_W-1:0]    commit_pd;
  logic [RD_W-1:0]    commit_rd;
  logic               commit_regf_we;
  logic               alloc_req;
  logic               alloc_valid;
  logic [PD_W-1:0]    alloc_pd;
  logic [OCC_W-1:0]   free_count;
  logic [RD_W-1:0]    query_arch;
  logic [PD_W-1:0]    query_pd;
  logic [COUNT_W-1:0] commit_count;
  logic               overflow_err;

  modport master (
    output commit_valid, commit_pd, commit_rd, commit_regf_we, alloc_req, query_arch,
    input  alloc_valid, alloc_pd, free_count, query_pd, commit_count, overflow_err
  );

  modport slave (
    input  commit_valid, commit_pd, commit_rd, commit_regf_we, alloc_req, query_arch,
    output alloc_valid, alloc_pd, free_count, query_pd, commit_count, overflow_err
  );
endinterface

// File: rtl/rrf_free_list.sv
// Retirement register file plus circular physical-register free list, fed by
// the ROB commit stream and drained by rename allocation.
module rrf_free_list #(
  parameter int unsigned NUM_PHYS = 64,
  parameter int unsigned NUM_ARCH = 32
) (
  input  logic             clk,
  input  logic             rst,
  rrf_free_list_if.slave   bus
);
  localparam int unsigned PD_W     = $clog2(NUM_PHYS);
  localparam int unsigned RD_W     = $clog2(NUM_ARCH);
  localparam int unsigned FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int unsigned IDX_W    = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W    = IDX_W + 1;
  localparam int unsigned COUNT_W  = 64;

  logic [PD_W-1:0]    rrf [NUM_ARCH];
  logic [PD_W-1:0]    fl  [FL_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [COUNT_W-1:0] commit_count;
  logic               overflow_err;

  logic               empty;
  logic               full;
  logic               commit_eff;
  logic               pop;
  logic               push_ok;
  logic               overflow_set;
  logic [PD_W-1:0]    old_pd;

  // Pointer-derived status and per-cycle events
  always_comb begin
    empty        = (head == tail);
    full         = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
    commit_eff   = bus.commit_valid && bus.commit_regf_we && (bus.commit_rd != RD_W'(0));
    pop          = bus.alloc_req && !empty;
    // A pop on a full list frees the slot the push lands in
    push_ok      = commit_eff && (!full || pop);
    overflow_set = commit_eff && full && !pop;
    old_pd       = rrf[bus.commit_rd];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= PTR_W'(FL_DEPTH);
      commit_count <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < NUM_ARCH; i++) rrf[i] <= PD_W'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PD_W'(NUM_ARCH + i);
    end else begin
      if (pop) head <= head + PTR_W'(1);
      if (push_ok) begin
        fl[tail[IDX_W-1:0]] <= old_pd;
        tail                <= tail + PTR_W'(1);
      end
      if (commit_eff) rrf[bus.commit_rd] <= bus.commit_pd;
      if (bus.commit_valid) commit_count <= commit_count + COUNT_W'(1);
      if (overflow_set) overflow_err <= 1'b1;
    end
  end

  // Outputs depend only on registered state (query_pd also on query_arch)
  always_comb begin
    bus.alloc_valid  = !empty;
    bus.alloc_pd     = fl[head[IDX_W-1:0]];
    bus.free_count   = tail - head;
    bus.query_pd     = rrf[bus.query_arch];
    bus.commit_count = commit_count;
    bus.overflow_err = overflow_err;
  end
endmodule

// File: doc/rrf_free_list.md
# rrf_free_list

Retirement-side partner of the reorder buffer. Consumes the ROB's one-per-cycle commit stream and maintains two structures:
- the retirement register file (RRF), the committed architectural-to-physical map;
- the physical-register free list, a circular FIFO.

Each committing write retires its new physical register into the RRF and returns the previously mapped physical register to the free list. The rename/dispatch stage draws new destination registers from the head of the free list.

## Interface
Parameters:
- NUM_PHYS, 64, number of physical registers; pd width = $clog2(NUM_PHYS) = 6
- NUM_ARCH, 32, number of architectural registers; free-list depth = NUM_PHYS - NUM_ARCH = 32

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- commit_valid  input  1  ROB dequeue strobe (ROB `dequeue_valid`)
- commit_pd  input  6  physical dest of committing entry (`rob_out.pd`)
- commit_rd  input  5  architectural dest (`rob_out.rvfi.monitor_rd_addr`)
- commit_regf_we  input  1  committing entry writes a register (`rob_out.rvfi.monitor_regf_we`)
- alloc_req  input  1  rename consumes the head free register this cycle
- alloc_valid  output  1  free list non-empty; alloc_pd is meaningful
- alloc_pd  output  6  head of free list (first-word fall-through)
- free_count  output  6  registered occupancy, 0..32
- query_arch  input  5  RRF read address
- query_pd  output  6  RRF[query_arch], combinational from registered state
- commit_count  output  64  number of retired instructions
- overflow_err  output  1  sticky; set by a push attempted into a full free list

## Operation
- State:
  - rrf[0..31], 6 bits each.
  - fl[0..31], 6 bits each.
  - head and tail pointers, 6 bits each (5 index bits + wrap bit).
  - commit_count.
  - overflow_err.
- Reset:
  - rrf[i]=i.
  - fl[i]=32+i.
  - head=6'b000000, tail=6'b100000 (list full).
  - free_count=32, alloc_valid=1, alloc_pd=32.
  - commit_count=0, overflow_err=0.
  - query_pd=query_arch.
- A commit is effective when commit_valid && commit_regf_we && commit_rd!=0. On an effective commit:
  - old = rrf[commit_rd], read before update;
  - rrf[commit_rd] <= commit_pd;
  - old is pushed into fl[tail[4:0]], tail += 1.
- Every commit with commit_valid=1 increments commit_count, whether or not it is effective.
- Commits with rd=0 or regf_we=0 change neither the RRF nor the free list.
- Allocation:
  - If alloc_req && alloc_valid, head += 1.
  - alloc_req while alloc_valid=0 is ignored: no pointer change, no error.
- Empty/full:
  - empty = head==tail.
  - full = index bits equal and wrap bits differ.
  - alloc_valid = !empty.
  - free_count = tail - head, computed modulo 64 and truncated to 6 bits. Value 32 means full.
- Simultaneous push and pop:
  - both pointers advance; occupancy is unchanged.
  - Legal when full, because the pop frees a slot. The push then writes the slot the pop vacates; head advances past it first in pointer order, so the data is correct.
  - Legal when non-empty.
- Empty list plus push in the same cycle:
  - no bypass; alloc_valid stays 0 that cycle;
  - the pushed register becomes visible next cycle.
- Push while full with no pop in the same cycle: the push is dropped (tail unchanged) and overflow_err is set. This is unreachable under correct ROB operation and exists to flag verification errors.
- Both pointers wrap naturally modulo 64.

## Timing
- alloc_pd, alloc_valid and free_count are functions of registered state only; none has a combinational path from alloc_req or commit_*.
- Commit-to-RRF latency: 1 cycle. query_pd reflects a commit on the edge after commit_valid.
- Commit-to-free-list latency: 1 cycle. The freed register can be allocated in the cycle after the commit at the earliest.
- Allocation: a pop on edge N exposes the next entry on alloc_pd after edge N.
- Reset has priority over all inputs in the same cycle. Reset mid-stream discards every in-flight push and pop and restores the reset state on the next edge.
- One commit per cycle maximum, matching the ROB dequeue rate.

## Test plan
- Reset check: assert rst 1 cycle -> alloc_valid=1, alloc_pd=32, free_count=32, query_pd(5)=5, commit_count=0, overflow_err=0.
- Drain: alloc_req=1 for 32 cycles -> alloc_pd sequence 32..63, then alloc_valid=0, free_count=0. A 33rd request leaves head unchanged and overflow_err=0.
- Commit after drain: commit rd=5, pd=40 -> next cycle query_pd(5)=40, alloc_valid=1, alloc_pd=5, free_count=1, commit_count=1.
- Non-effective commits: commit rd=0 pd=41, then regf_we=0 pd=42 -> RRF and free_count unchanged, commit_count increases by 2.
- Simultaneous events:
  - From full, alloc_req plus commit rd=3 pd=33 in the same cycle -> free_count stays 32, alloc_pd advances to 33, old pd 3 lands at the tail.
  - With the list empty, alloc_req plus commit in the same cycle -> alloc_valid=0 that cycle, 1 the next cycle.
- Overflow and mid-operation reset:
  - From reset (full), commit rd=7 pd=50 with no alloc -> overflow_err=1 (sticky), free_count=32.
  - A following rst restores all reset values.
